// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program-counter sequencer:
//   - br_op_e     : branch-condition encodings driven by decode
//   - seq_state_e : pending-redirect states (IDLE / HELD)
//   - DEF_*       : default reset PC, register-jump base and exception vector
//   - misaligned(): word-alignment test applied to non-sequential targets
// -----------------------------------------------------------------------------
package pc_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_GEZ  = 3'd3,
    BR_GTZ  = 3'd4,
    BR_LEZ  = 3'd5,
    BR_LTZ  = 3'd6,
    BR_RSVD = 3'd7
  } br_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } seq_state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_REG_BASE = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

  // Instruction fetch is word-addressed; any set low bit is a bad target.
  function automatic logic misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/pc_sequencer_br_cond.sv
// -----------------------------------------------------------------------------
// br_cond
// Combinational branch-condition evaluator.
//   br_op  : branch encoding (br_op_e); BR_NONE and BR_RSVD never take
//   zero   : ALU equality flag, used by eq/ne
//   rs_val : register operand, interpreted as signed for the *z compares
//   taken  : condition holds (not qualified by ctl_valid here)
// -----------------------------------------------------------------------------
module br_cond
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      br_op,
  input  logic            zero,
  input  logic [XLEN-1:0] rs_val,
  output logic            taken
);

  logic msb;
  logic is_zero;

  assign msb     = rs_val[XLEN-1];
  assign is_zero = (rs_val == '0);

  always_comb begin
    taken = 1'b0;
    case (br_op_e'(br_op))
      BR_EQ:   taken = zero;
      BR_NE:   taken = ~zero;
      BR_GEZ:  taken = ~msb;
      BR_GTZ:  taken = ~msb & ~is_zero;
      BR_LEZ:  taken = msb | is_zero;
      BR_LTZ:  taken = msb;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Owns the PC register and selects the next PC every cycle.
//
// Parameters
//   XLEN      : address/operand width (>= 32)
//   RESET_PC  : PC after reset
//   REG_BASE  : offset added to rs_val for jr/jalr
//   EXC_VEC   : exception / misaligned-target vector
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall               : hold pc; a redirect resolved now is kept pending
//   ctl_valid           : br_op/jmp/jreg describe the instruction at pc
//   br_op, zero, rs_val : branch condition inputs (see br_cond)
//   jmp, target26       : absolute jump and its word index
//   jreg                : register jump to rs_val + REG_BASE
//   imm16               : signed word offset for taken branches
//   exc_req             : exception request, honoured even without ctl_valid
//   pc                  : current PC
//   link_addr           : pc + 4
//   redirect            : pc loads a non-sequential value at the next edge
//   addr_err            : one-cycle pulse following a misaligned-target trap
//   epc, badvaddr       : trapping PC and offending target
// -----------------------------------------------------------------------------
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
  parameter logic [XLEN-1:0] REG_BASE = XLEN'(DEF_REG_BASE),
  parameter logic [XLEN-1:0] EXC_VEC  = XLEN'(DEF_EXC_VEC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            ctl_valid,
  input  logic [2:0]      br_op,
  input  logic            zero,
  input  logic            jmp,
  input  logic            jreg,
  input  logic [XLEN-1:0] rs_val,
  input  logic [15:0]     imm16,
  input  logic [25:0]     target26,
  input  logic            exc_req,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] link_addr,
  output logic            redirect,
  output logic            addr_err,
  output logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] badvaddr
);

  seq_state_e      state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] pend_pc_reg, pend_pc_next;
  logic [XLEN-1:0] epc_reg, epc_next;
  logic [XLEN-1:0] badvaddr_reg, badvaddr_next;
  logic            addr_err_reg, addr_err_next;

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] jmp_pc;
  logic [XLEN-1:0] jreg_pc;
  logic [XLEN-1:0] raw_target;
  logic [XLEN-1:0] resolved_target;
  logic [XLEN-1:0] held_target;
  logic            cond_taken;
  logic            nonseq;
  logic            misalign;

  // ---------------------------------------------------------------------------
  // Target arithmetic (all wraps modulo 2^XLEN)
  // ---------------------------------------------------------------------------
  br_cond #(
    .XLEN (XLEN)
  ) u_br_cond (
    .br_op  (br_op),
    .zero   (zero),
    .rs_val (rs_val),
    .taken  (cond_taken)
  );

  assign seq_pc  = pc_reg + XLEN'(4);
  // Branch base is always pc+4; the word offset is sign-extended then <<2.
  assign br_pc   = seq_pc + {{(XLEN-18){imm16[15]}}, imm16, 2'b00};
  assign jmp_pc  = {pc_reg[XLEN-1:28], target26, 2'b00};
  assign jreg_pc = rs_val + REG_BASE;

  // Priority: exception, register jump, absolute jump, taken branch, sequential.
  always_comb begin
    raw_target = seq_pc;
    nonseq     = 1'b1;
    if (exc_req) begin
      raw_target = EXC_VEC;
    end else if (ctl_valid && jreg) begin
      raw_target = jreg_pc;
    end else if (ctl_valid && jmp) begin
      raw_target = jmp_pc;
    end else if (ctl_valid && cond_taken) begin
      raw_target = br_pc;
    end else begin
      nonseq = 1'b0;
    end
  end

  // The exception vector itself is trusted and never alignment-checked.
  assign misalign        = nonseq & ~exc_req & misaligned(raw_target[1:0]);
  assign resolved_target = misalign ? EXC_VEC : raw_target;

  // While a redirect is held, an exception replaces it.
  assign held_target = exc_req ? EXC_VEC : pend_pc_reg;

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    pend_pc_next  = pend_pc_reg;
    epc_next      = epc_reg;
    badvaddr_next = badvaddr_reg;
    addr_err_next = 1'b0;
    redirect      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (nonseq) begin
          // Trap side-effects happen when the redirect resolves, even if
          // the redirect itself has to wait for the stall to release.
          if (exc_req || misalign) begin
            epc_next = pc_reg;
          end
          if (misalign) begin
            badvaddr_next = raw_target;
            addr_err_next = 1'b1;
          end
          if (stall) begin
            state_next   = HELD;
            pend_pc_next = resolved_target;
          end else begin
            pc_next  = resolved_target;
            redirect = 1'b1;
          end
        end else if (!stall) begin
          pc_next = seq_pc;
        end
      end

      HELD: begin
        // Control inputs belong to an instruction that will be squashed by
        // the held redirect, so only exc_req is looked at here.
        if (stall) begin
          pend_pc_next = held_target;
        end else begin
          state_next = IDLE;
          pc_next    = held_target;
          redirect   = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      pend_pc_reg  <= '0;
      epc_reg      <= '0;
      badvaddr_reg <= '0;
      addr_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      pend_pc_reg  <= pend_pc_next;
      epc_reg      <= epc_next;
      badvaddr_reg <= badvaddr_next;
      addr_err_reg <= addr_err_next;
    end
  end

  assign pc        = pc_reg;
  assign link_addr = seq_pc;
  assign addr_err  = addr_err_reg;
  assign epc       = epc_reg;
  assign badvaddr  = badvaddr_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Scoreboard bench for pc_sequencer. The stimulus process drives inputs on
// the falling edge, asks a behavioural model what the DUT must show in this
// cycle, and queues that expectation; a monitor pops and compares shortly
// after. A second, 64-bit instance covers wrap-around and the bit-63 sign.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] RBASE  = 32'h0000_3000;
  localparam logic [31:0] EVEC   = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        ctl_valid;
  logic [2:0]  br_op;
  logic        zero;
  logic        jmp;
  logic        jreg;
  logic [31:0] rs_val;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic        exc_req;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        redirect;
  logic        addr_err;
  logic [31:0] epc;
  logic [31:0] badvaddr;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .ctl_valid (ctl_valid),
    .br_op     (br_op),
    .zero      (zero),
    .jmp       (jmp),
    .jreg      (jreg),
    .rs_val    (rs_val),
    .imm16     (imm16),
    .target26  (target26),
    .exc_req   (exc_req),
    .pc        (pc),
    .link_addr (link_addr),
    .redirect  (redirect),
    .addr_err  (addr_err),
    .epc       (epc),
    .badvaddr  (badvaddr)
  );

  // 64-bit build
  logic        rst64_n;
  logic        ctl_valid64;
  logic [2:0]  br_op64;
  logic [63:0] rs_val64;
  logic [15:0] imm16_64;
  logic [63:0] pc64;
  logic [63:0] link64;
  logic        redirect64;
  logic        addr_err64;
  logic [63:0] epc64;
  logic [63:0] bad64;

  pc_sequencer #(
    .XLEN     (64),
    .RESET_PC (64'hFFFF_FFFF_FFFF_FFF8),
    .REG_BASE (64'h0000_0000_0000_3000),
    .EXC_VEC  (64'h0000_0000_0000_4180)
  ) dut64 (
    .clk       (clk),
    .rst_n     (rst64_n),
    .stall     (1'b0),
    .ctl_valid (ctl_valid64),
    .br_op     (br_op64),
    .zero      (1'b0),
    .jmp       (1'b0),
    .jreg      (1'b0),
    .rs_val    (rs_val64),
    .imm16     (imm16_64),
    .target26  (26'd0),
    .exc_req   (1'b0),
    .pc        (pc64),
    .link_addr (link64),
    .redirect  (redirect64),
    .addr_err  (addr_err64),
    .epc       (epc64),
    .badvaddr  (bad64)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: architectural state only
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] link;
    logic        redirect;
    logic        addr_err;
    logic [31:0] epc;
    logic [31:0] bad;
  } exp_t;

  exp_t sb_q[$];

  logic [31:0] m_pc;
  bit          m_pend_v;
  logic [31:0] m_pend_pc;
  logic [31:0] m_epc;
  logic [31:0] m_bad;
  logic        m_aerr;

  task automatic model_reset();
    m_pc      = RST_PC;
    m_pend_v  = 0;
    m_pend_pc = '0;
    m_epc     = '0;
    m_bad     = '0;
    m_aerr    = 1'b0;
  endtask

  function automatic bit model_taken(input logic [2:0] op, input logic z, input logic [31:0] rs);
    case (op)
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return $signed(rs) >= 0;
      3'd4:    return $signed(rs) > 0;
      3'd5:    return $signed(rs) <= 0;
      3'd6:    return $signed(rs) < 0;
      default: return 0;
    endcase
  endfunction

  // Called just after a falling edge: queue this cycle's expectation,
  // advance the model across the coming rising edge, wait a cycle.
  task automatic step();
    exp_t        e;
    logic [31:0] tgt;
    bit          ns;
    bit          mis;
    bit          fired;
    e.pc       = m_pc;
    e.link     = m_pc + 32'd4;
    e.epc      = m_epc;
    e.bad      = m_bad;
    e.addr_err = m_aerr;
    e.redirect = 1'b0;
    fired      = 0;
    if (!m_pend_v) begin
      ns = 1;
      if (exc_req)                                             tgt = EVEC;
      else if (ctl_valid && jreg)                              tgt = rs_val + RBASE;
      else if (ctl_valid && jmp)                               tgt = {m_pc[31:28], target26, 2'b00};
      else if (ctl_valid && model_taken(br_op, zero, rs_val))  tgt = m_pc + 32'd4 + 32'(int'($signed(imm16)) * 4);
      else begin
        ns  = 0;
        tgt = m_pc + 32'd4;
      end
      mis = ns && !exc_req && (tgt % 4 != 0);
      if (exc_req || mis) m_epc = m_pc;
      if (mis) begin
        m_bad = tgt;
        tgt   = EVEC;
        fired = 1;
      end
      if (stall) begin
        if (ns) begin
          m_pend_v  = 1;
          m_pend_pc = tgt;
        end
      end else begin
        m_pc       = tgt;
        e.redirect = ns;
      end
    end else begin
      if (exc_req) m_pend_pc = EVEC;
      if (!stall) begin
        m_pc       = m_pend_pc;
        m_pend_v   = 0;
        e.redirect = 1'b1;
      end
    end
    m_aerr = fired;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    stall     = 1'b0;
    ctl_valid = 1'b0;
    br_op     = 3'd0;
    zero      = 1'b0;
    jmp       = 1'b0;
    jreg      = 1'b0;
    rs_val    = '0;
    imm16     = '0;
    target26  = '0;
    exc_req   = 1'b0;
  endtask

  task automatic junk_controls();
    ctl_valid = 1'b1;
    br_op     = 3'($urandom_range(0, 7));
    zero      = 1'($urandom_range(0, 1));
    jmp       = 1'($urandom_range(0, 1));
    jreg      = 1'($urandom_range(0, 1));
    rs_val    = $urandom;
    imm16     = 16'($urandom);
    target26  = 26'($urandom);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        n_txn++;
        check("pc",        64'(pc),        64'(e.pc));
        check("link_addr", 64'(link_addr), 64'(e.link));
        check("redirect",  64'(redirect),  64'(e.redirect));
        check("addr_err",  64'(addr_err),  64'(e.addr_err));
        check("epc",       64'(epc),       64'(e.epc));
        check("badvaddr",  64'(badvaddr),  64'(e.bad));
        $display("txn %0d pc=%h redirect=%b addr_err=%b epc=%h badvaddr=%h",
                 n_txn, pc, redirect, addr_err, epc, badvaddr);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // 64-bit directed checks: wrap at 2^64-4 and ltz on bit 63
  // ---------------------------------------------------------------------------
  initial begin
    rst64_n     = 1'b0;
    ctl_valid64 = 1'b0;
    br_op64     = 3'd0;
    rs_val64    = '0;
    imm16_64    = '0;
    repeat (3) @(negedge clk);
    check("x64_reset_pc", pc64, 64'hFFFF_FFFF_FFFF_FFF8);
    rst64_n = 1'b1;
    @(negedge clk);
    check("x64_pc_top", pc64, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    check("x64_wrap", pc64, 64'h0);
    ctl_valid64 = 1'b1;
    br_op64     = 3'd6;
    rs_val64    = 64'h8000_0000_0000_0000;
    imm16_64    = 16'h0010;
    #1;
    check("x64_ltz_taken", 64'(redirect64), 64'd1);
    check("x64_link", link64, 64'h4);
    @(negedge clk);
    check("x64_ltz_pc", pc64, 64'h44);
    rs_val64 = 64'h0000_0000_8000_0000;
    #1;
    check("x64_ltz_bit31", 64'(redirect64), 64'd0);
    @(negedge clk);
    check("x64_seq_pc", pc64, 64'h48);
    check("x64_addr_err", 64'(addr_err64), 64'd0);
    check("x64_epc", epc64, 64'd0);
    check("x64_badvaddr", bad64, 64'd0);
    ctl_valid64 = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_pc",       64'(pc),       64'(RST_PC));
    check("reset_epc",      64'(epc),      64'd0);
    check("reset_badvaddr", 64'(badvaddr), 64'd0);
    check("reset_addr_err", 64'(addr_err), 64'd0);
    check("reset_redirect", 64'(redirect), 64'd0);

    // Sequential from reset: 3000, 3004, 3008, 300C
    rst_n = 1'b1;
    repeat (4) step();

    // gtz taken backward: 3010 -> 300C
    ctl_valid = 1'b1; br_op = 3'd4; rs_val = 32'd5; imm16 = 16'hFFFE;
    step();
    clear_inputs();
    step();
    // same branch with rs_val = 0: not taken, 3010 -> 3014
    ctl_valid = 1'b1; br_op = 3'd4; rs_val = 32'd0; imm16 = 16'hFFFE;
    step();
    clear_inputs();

    // Misaligned register jump: 0x22 + 0x3000 traps
    ctl_valid = 1'b1; jreg = 1'b1; rs_val = 32'h22;
    step();
    clear_inputs();
    repeat (2) step();

    // Jump under a 3-cycle stall, later controls ignored
    stall = 1'b1; ctl_valid = 1'b1; jmp = 1'b1; target26 = 26'h40;
    step();
    repeat (2) begin
      junk_controls();
      step();
    end
    junk_controls();
    stall = 1'b0;
    step();
    clear_inputs();
    step();

    // Exception while HELD replaces the held jump
    stall = 1'b1; ctl_valid = 1'b1; jmp = 1'b1; target26 = 26'h80;
    step();
    clear_inputs(); stall = 1'b1; exc_req = 1'b1;
    step();
    exc_req = 1'b0;
    step();
    stall = 1'b0;
    step();
    step();

    // Stall and exc_req together from IDLE
    stall = 1'b1; exc_req = 1'b1;
    step();
    clear_inputs();
    repeat (2) step();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      clear_inputs();
      stall     = ($urandom_range(0, 3) == 0);
      ctl_valid = ($urandom_range(0, 9) < 7);
      br_op     = 3'($urandom_range(0, 7));
      zero      = 1'($urandom_range(0, 1));
      jmp       = ($urandom_range(0, 9) == 0);
      jreg      = ($urandom_range(0, 9) == 0);
      exc_req   = ($urandom_range(0, 39) == 0);
      imm16     = 16'($urandom);
      target26  = 26'($urandom);
      case ($urandom_range(0, 5))
        0:       rs_val = 32'h0;
        1:       rs_val = 32'h8000_0000;
        2:       rs_val = 32'hFFFF_FFFF;
        3:       rs_val = 32'h1;
        4:       rs_val = $urandom & 32'h0000_0FFC;
        default: rs_val = $urandom;
      endcase
      step();
    end

    // Reset asserted while HELD discards the pending redirect
    clear_inputs();
    stall = 1'b1; ctl_valid = 1'b1; jmp = 1'b1; target26 = 26'h123;
    step();
    clear_inputs();
    stall = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_pc",       64'(pc),       64'(RST_PC));
    check("async_reset_epc",      64'(epc),      64'd0);
    check("async_reset_addr_err", 64'(addr_err), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    repeat (3) step();

    #3;
    check("scoreboard_drain", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-issue MIPS-subset core. It owns the PC register and evaluates the next PC each cycle: sequential, conditional branch, absolute jump, register jump and exception vector. It holds a redirect that resolves during a stall until the stall releases, and traps misaligned targets. It sits between the decode/ALU stage, which supplies control, operands and zero flag, and instruction memory, which consumes `pc`.

## Interface
- `XLEN`, default 32: address/operand width, at least 32.
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `REG_BASE`, default 32'h0000_3000: added to `rs_val` for jr/jalr targets.
- `EXC_VEC`, default 32'h0000_4180: exception/trap vector.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `stall`, in, 1: hold the PC; a redirect computed this cycle is captured as pending.
- `ctl_valid`, in, 1: the control inputs below describe the instruction at `pc`.
- `br_op`, in, 3: 0 none, 1 eq (zero), 2 ne (!zero), 3 gez, 4 gtz, 5 lez, 6 ltz; 7 is reserved and behaves as none.
- `zero`, in, 1: ALU equality flag.
- `jmp`, in, 1: j/jal absolute jump.
- `jreg`, in, 1: jr/jalr register jump.
- `rs_val`, in, XLEN: register operand used for the compare and for the jr target.
- `imm16`, in, 16: branch offset in words, signed.
- `target26`, in, 26: jump index.
- `exc_req`, in, 1: external exception request.
- `pc`, out, XLEN: current PC register.
- `link_addr`, out, XLEN: `pc`+4, combinational.
- `redirect`, out, 1: the PC loads a non-sequential value at the next edge.
- `addr_err`, out, 1: one-cycle pulse, registered, that follows a misaligned-target trap.
- `epc`, out, XLEN: PC of the trapping instruction.
- `badvaddr`, out, XLEN: offending target.

## Operation
- Raw target, chosen by priority: `exc_req`, then `jreg`, then `jmp`, then taken branch, then sequential.
  - `exc_req`: EXC_VEC.
  - `jreg`: `rs_val`+REG_BASE.
  - `jmp`: {pc[XLEN-1:28], target26, 2'b00}.
  - Taken branch: pc+4+(sext(imm16)<<2). The base is always pc+4.
  - Sequential: pc+4.
- Branch conditions use signed `rs_val`:
  - gez: !rs_val[XLEN-1].
  - gtz: !msb && rs_val!=0.
  - lez: msb || rs_val==0.
  - ltz: msb.
- `jreg`, `jmp` and `br_op` are ignored when `ctl_valid`=0. `exc_req` is honoured regardless of `ctl_valid`.
- Misalignment: a non-sequential target with bits[1:0]≠0 traps.
  - `epc`←pc, `badvaddr`←target, next PC = EXC_VEC, `addr_err` pulses next cycle.
  - The `exc_req` target EXC_VEC is never checked.
  - Arithmetic wraps modulo 2^XLEN and is not flagged.
- Pending register: `pend_v`, `pend_pc`.
  - States are IDLE (`pend_v`=0) and HELD (`pend_v`=1).
  - IDLE→HELD when `stall`=1 and a redirect or trap resolves; target captured, trap side-effects applied at capture.
  - In HELD, new control inputs are ignored. `exc_req` overwrites `pend_pc` with EXC_VEC.
  - HELD→IDLE on the first cycle with `stall`=0; pc←`pend_pc`.
- `redirect`=1 on a non-stalled cycle whose next PC is non-sequential, or on HELD release.
- `epc`/`badvaddr` update only on a misalignment trap. For `exc_req`, `epc`←pc.

## Timing
- Reset values: pc=RESET_PC, pend_v=0, epc=0, badvaddr=0, addr_err=0.
- Target logic is combinational from current pc and inputs. pc updates one edge later, giving zero-bubble redirect when not stalled.
- `stall`=1 with no pending: pc holds; `link_addr` stays pc+4.
- `stall` and `exc_req` in the same cycle: HELD with EXC_VEC.
- Reset asserted mid-HELD: the pending redirect is discarded and pc=RESET_PC.
- `rst_n` release: the first edge after deassertion loads RESET_PC+4, or the computed target.

## Structure
- Shared package `pc_pkg`:
  - `br_op` encodings (BR_NONE…BR_LTZ).
  - Default RESET_PC, REG_BASE and EXC_VEC constants.
- One natural sub-module, `br_cond`: combinational, evaluates `br_op`/`zero`/`rs_val` to `taken`.
- The PC, pending and trap registers stay in `pc_sequencer`.

## Test plan
- Reset, no control: pc = 3000 → 3004 → 3008; `redirect`=0.
- Branch: pc=3010, br_op=gtz, rs_val=5, imm16=16'hFFFE, ctl_valid=1 → next pc=300C, `redirect`=1. The same stimulus with rs_val=0 → 3014.
- Register jump: jreg with rs_val=0x22 → target 3022 misaligned → pc=4180, epc=old pc, badvaddr=3022, `addr_err` pulse one cycle later.
- Jump under stall: jmp with target26=0x40 while stall=1 for 3 cycles → pc holds, new controls ignored. On release, pc={pc[31:28],0x100}; `redirect` high exactly that cycle.
- Exception during HELD: exc_req during HELD → release loads 4180. Reset asserted mid-HELD → pc=3000, pend_v=0 immediately (asynchronous).
- XLEN=64 build: sequential wrap at 2^64-4 → 0; ltz uses bit 63.
